sdr_port_arbiter: RTL and testbench

- Round-robin arbiter that shares the single local-bus request port of the SDRAM controller core among NPORTS independent requesters (e.g. AHB slave, DMA, video fetch).
- Latches the winning requester's command and presents it to the controller as one registered request.
- Holds the grant until the burst's data beats complete, and steers controller handshakes back only to the granted port.
- Sits between the requester masters and the controller's RADDR/R_REQ/W_REQ/B_SIZE/AUTO_PCH inputs.

---
 rtl/sdr_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sdr_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_port_arbiter.sv
// sdr_port_arbiter: round-robin sharing of the SDRAM controller
// local-bus request port among NPORTS requesters.
module sdr_port_arbiter #(
   parameter int NPORTS       = 4,
   parameter int SDRAM_RASIZE = 31,
   parameter int PTRBITS      = 2
) (
   input  logic                           CLK,
   input  logic                           RESET_N,
   input  logic [NPORTS*SDRAM_RASIZE-1:0] P_RADDR,
   input  logic [NPORTS-1:0]              P_R_REQ,
   input  logic [NPORTS-1:0]              P_W_REQ,
   input  logic [NPORTS*4-1:0]            P_B_SIZE,
   input  logic [NPORTS-1:0]              P_AUTO_PCH,
   output logic [NPORTS-1:0]              P_RW_ACK,
   output logic [NPORTS-1:0]              P_R_VALID,
   output logic [NPORTS-1:0]              P_D_REQ,
   output logic [NPORTS-1:0]              P_W_VALID,
   output logic [NPORTS-1:0]              GRANT,
   output logic                           BUSY,
   output logic [SDRAM_RASIZE-1:0]        CTL_RADDR,
   output logic                           CTL_R_REQ,
   output logic                           CTL_W_REQ,
   output logic [3:0]                     CTL_B_SIZE,
   output logic                           CTL_AUTO_PCH,
   input  logic                           CTL_RW_ACK,
   input  logic                           CTL_R_VALID,
   input  logic                           CTL_D_REQ,
   input  logic                           CTL_W_VALID
);

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA
   } state_t;

   state_t                  state;
   logic [PTRBITS-1:0]      ptr;
   logic [PTRBITS-1:0]      own;
   logic                    rd_burst;
   logic [4:0]              beats;

   logic [NPORTS-1:0]       req;
   logic [2*NPORTS-1:0]     req_dbl;
   logic [NPORTS-1:0]       req_rot;
   logic                    win_vld;
   logic [PTRBITS-1:0]      win;
   int                      win_sum;
   int                      nxt_sum;
   logic [PTRBITS-1:0]      ptr_nxt;

   logic [SDRAM_RASIZE-1:0] sel_addr;
   logic [3:0]              sel_bsz;
   logic                    sel_r;
   logic                    sel_w;
   logic                    sel_ap;
   logic [NPORTS-1:0]       grant_nxt;
   logic                    beat;
   logic [4:0]              beat_load;

   // Rotate so bit 0 is the pointer's port; lowest set bit wins.
   always_comb begin
      req     = P_R_REQ | P_W_REQ;
      req_dbl = {req, req} >> ptr;
      req_rot = req_dbl[NPORTS-1:0];
      win_vld = 1'b0;
      win_sum = 0;
      for (int k = NPORTS - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            win_vld = 1'b1;
            win_sum = int'(ptr) + k;
         end
      end
      if (win_sum >= NPORTS) begin
         win_sum = win_sum - NPORTS;
      end
      win = PTRBITS'(win_sum);
   end

   always_comb begin
      nxt_sum = int'(own) + 1;
      if (nxt_sum >= NPORTS) begin
         nxt_sum = 0;
      end
      ptr_nxt = PTRBITS'(nxt_sum);
   end

   always_comb begin
      sel_addr  = '0;
      sel_bsz   = '0;
      sel_r     = 1'b0;
      sel_w     = 1'b0;
      sel_ap    = 1'b0;
      grant_nxt = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (win == PTRBITS'(i)) begin
            sel_addr     = P_RADDR[i*SDRAM_RASIZE +: SDRAM_RASIZE];
            sel_bsz      = P_B_SIZE[i*4 +: 4];
            sel_r        = P_R_REQ[i];
            sel_w        = P_W_REQ[i];
            sel_ap       = P_AUTO_PCH[i];
            grant_nxt[i] = 1'b1;
         end
      end
   end

   assign beat      = rd_burst ? CTL_R_VALID : CTL_W_VALID;
   assign beat_load = (CTL_B_SIZE == 4'd0) ? 5'd16 : {1'b0, CTL_B_SIZE};

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state        <= IDLE;
         ptr          <= '0;
         own          <= '0;
         rd_burst     <= 1'b0;
         beats        <= '0;
         GRANT        <= '0;
         BUSY         <= 1'b0;
         CTL_RADDR    <= '0;
         CTL_R_REQ    <= 1'b0;
         CTL_W_REQ    <= 1'b0;
         CTL_B_SIZE   <= '0;
         CTL_AUTO_PCH <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (win_vld) begin
                  CTL_RADDR    <= sel_addr;
                  CTL_B_SIZE   <= sel_bsz;
                  CTL_AUTO_PCH <= sel_ap;
                  CTL_R_REQ    <= sel_r;
                  CTL_W_REQ    <= sel_w & ~sel_r;
                  rd_burst     <= sel_r;
                  own          <= win;
                  GRANT        <= grant_nxt;
                  BUSY         <= 1'b1;
                  state        <= CMD;
               end
            end
            CMD: begin
               // Requests stay up until the controller has registered them.
               if (CTL_RW_ACK) begin
                  CTL_R_REQ <= 1'b0;
                  CTL_W_REQ <= 1'b0;
                  beats     <= beat_load;
                  state     <= DATA;
               end
            end
            DATA: begin
               if (beat) begin
                  beats <= beats - 5'd1;
                  if (beats == 5'd1) begin
                     GRANT <= '0;
                     BUSY  <= 1'b0;
                     ptr   <= ptr_nxt;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign P_RW_ACK  = {NPORTS{CTL_RW_ACK}}  & GRANT;
   assign P_R_VALID = {NPORTS{CTL_R_VALID}} & GRANT;
   assign P_D_REQ   = {NPORTS{CTL_D_REQ}}   & GRANT;
   assign P_W_VALID = {NPORTS{CTL_W_VALID}} & GRANT;

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// tb_sdr_port_arbiter: vector table, corner sequences and
// randomized traffic against a round-robin reference model.
module tb_sdr_port_arbiter;

   localparam int NP = 4;
   localparam int RA = 31;

   logic             CLK;
   logic             RESET_N;
   logic [NP*RA-1:0] P_RADDR;
   logic [NP-1:0]    P_R_REQ;
   logic [NP-1:0]    P_W_REQ;
   logic [NP*4-1:0]  P_B_SIZE;
   logic [NP-1:0]    P_AUTO_PCH;
   logic [NP-1:0]    P_RW_ACK;
   logic [NP-1:0]    P_R_VALID;
   logic [NP-1:0]    P_D_REQ;
   logic [NP-1:0]    P_W_VALID;
   logic [NP-1:0]    GRANT;
   logic             BUSY;
   logic [RA-1:0]    CTL_RADDR;
   logic             CTL_R_REQ;
   logic             CTL_W_REQ;
   logic [3:0]       CTL_B_SIZE;
   logic             CTL_AUTO_PCH;
   logic             CTL_RW_ACK;
   logic             CTL_R_VALID;
   logic             CTL_D_REQ;
   logic             CTL_W_VALID;

   int checks;
   int errors;

   sdr_port_arbiter #(
      .NPORTS(NP),
      .SDRAM_RASIZE(RA),
      .PTRBITS(2)
   ) dut (
      .CLK(CLK),
      .RESET_N(RESET_N),
      .P_RADDR(P_RADDR),
      .P_R_REQ(P_R_REQ),
      .P_W_REQ(P_W_REQ),
      .P_B_SIZE(P_B_SIZE),
      .P_AUTO_PCH(P_AUTO_PCH),
      .P_RW_ACK(P_RW_ACK),
      .P_R_VALID(P_R_VALID),
      .P_D_REQ(P_D_REQ),
      .P_W_VALID(P_W_VALID),
      .GRANT(GRANT),
      .BUSY(BUSY),
      .CTL_RADDR(CTL_RADDR),
      .CTL_R_REQ(CTL_R_REQ),
      .CTL_W_REQ(CTL_W_REQ),
      .CTL_B_SIZE(CTL_B_SIZE),
      .CTL_AUTO_PCH(CTL_AUTO_PCH),
      .CTL_RW_ACK(CTL_RW_ACK),
      .CTL_R_VALID(CTL_R_VALID),
      .CTL_D_REQ(CTL_D_REQ),
      .CTL_W_VALID(CTL_W_VALID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_port(input int i, input logic [RA-1:0] a,
                           input logic [3:0] b, input logic ap);
      P_RADDR[i*RA +: RA] = a;
      P_B_SIZE[i*4 +: 4]  = b;
      P_AUTO_PCH[i]       = ap;
   endtask

   task automatic issue(input logic [3:0] r, input logic [3:0] w,
                        input logic [3:0] g, input logic er,
                        input logic ew, input logic [RA-1:0] ea,
                        input logic [3:0] eb, input logic eap);
      P_R_REQ = r;
      P_W_REQ = w;
      #1;
      chk("pre_grant", GRANT, 0);
      step();
      chk("grant", GRANT, g);
      chk("busy", BUSY, 1);
      chk("ctl_r_req", CTL_R_REQ, er);
      chk("ctl_w_req", CTL_W_REQ, ew);
      chk("ctl_raddr", CTL_RADDR, ea);
      chk("ctl_b_size", CTL_B_SIZE, eb);
      chk("ctl_auto_pch", CTL_AUTO_PCH, eap);
   endtask

   task automatic beats(input logic [3:0] g, input logic rd,
                        input int nb);
      for (int b = 0; b < nb; b++) begin
         if ($urandom_range(0, 3) == 0) begin
            step();
            chk("gap_busy", BUSY, 1);
         end
         if (rd) begin
            CTL_R_VALID = 1'b1;
         end else begin
            CTL_W_VALID = 1'b1;
            CTL_D_REQ   = 1'b1;
         end
         #1;
         chk("p_valid", rd ? P_R_VALID : P_W_VALID, g);
         chk("p_d_req", P_D_REQ, rd ? 4'b0000 : g);
         step();
         CTL_R_VALID = 1'b0;
         CTL_W_VALID = 1'b0;
         CTL_D_REQ   = 1'b0;
         if (b < nb - 1) begin
            chk("busy_mid", BUSY, 1);
         end else begin
            chk("busy_end", BUSY, 0);
            chk("grant_end", GRANT, 0);
            chk("req_end", {CTL_R_REQ, CTL_W_REQ}, 0);
         end
      end
   endtask

   task automatic run_txn(input logic [3:0] g, input logic rd,
                          input int nb, input int dly, input bit drop);
      if (drop) begin
         P_R_REQ = '0;
         P_W_REQ = '0;
      end
      repeat (dly) begin
         step();
         chk("hold_r", CTL_R_REQ, rd);
         chk("hold_w", CTL_W_REQ, !rd);
         chk("hold_g", GRANT, g);
      end
      CTL_RW_ACK = 1'b1;
      #1;
      chk("p_rw_ack", P_RW_ACK, g);
      step();
      CTL_RW_ACK = 1'b0;
      chk("req_drop", {CTL_R_REQ, CTL_W_REQ}, 0);
      beats(g, rd, nb);
   endtask

   typedef struct {
      logic [3:0]    r;
      logic [3:0]    w;
      logic [3:0]    bsz;
      logic [3:0]    ap;
      logic [3:0]    g;
      logic          er;
      logic          ew;
      logic [RA-1:0] ea;
      logic [3:0]    eb;
      logic          eap;
      int            nb;
      int            dly;
   } vec_t;

   vec_t          tbl[8];
   logic [RA-1:0] ra[NP];
   logic [3:0]    rb[NP];
   logic          rap[NP];
   logic [3:0]    rm;
   logic [3:0]    wm;
   logic [3:0]    req;
   int            mptr;
   int            w;
   int            idx;
   logic [3:0]    g;

   initial begin
      checks = 0;
      errors = 0;
      tbl[0] = '{4'b0010, 4'b0000, 4'd3, 4'b0010, 4'b0010,
                 1, 0, 31'h0001_2340, 4'd4, 1, 4, 5};
      tbl[1] = '{4'b0100, 4'b0100, 4'd0, 4'b0000, 4'b0100,
                 1, 0, 31'h0001_2350, 4'd2, 0, 2, 0};
      tbl[2] = '{4'b0000, 4'b1111, 4'd14, 4'b1010, 4'b1000,
                 0, 1, 31'h0001_2360, 4'd1, 1, 1, 1};
      tbl[3] = '{4'b0000, 4'b1111, 4'd0, 4'b0000, 4'b0001,
                 0, 1, 31'h0001_2330, 4'd0, 0, 16, 2};
      tbl[4] = '{4'b0011, 4'b0000, 4'd5, 4'b0101, 4'b0010,
                 1, 0, 31'h0001_2340, 4'd6, 0, 6, 0};
      tbl[5] = '{4'b0001, 4'b1000, 4'd1, 4'b1000, 4'b1000,
                 0, 1, 31'h0001_2360, 4'd4, 1, 4, 3};
      tbl[6] = '{4'b0000, 4'b0110, 4'd2, 4'b0100, 4'b0010,
                 0, 1, 31'h0001_2340, 4'd3, 0, 3, 1};
      tbl[7] = '{4'b1001, 4'b0000, 4'd0, 4'b0001, 4'b1000,
                 1, 0, 31'h0001_2360, 4'd3, 0, 3, 2};

      RESET_N     = 1'b0;
      P_RADDR     = '0;
      P_R_REQ     = '0;
      P_W_REQ     = '0;
      P_B_SIZE    = '0;
      P_AUTO_PCH  = '0;
      CTL_RW_ACK  = 1'b1;
      CTL_R_VALID = 1'b1;
      CTL_D_REQ   = 1'b1;
      CTL_W_VALID = 1'b1;
      step();
      step();
      chk("rst_grant", GRANT, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_ctl", {CTL_R_REQ, CTL_W_REQ, CTL_B_SIZE, CTL_AUTO_PCH}, 0);
      chk("rst_raddr", CTL_RADDR, 0);
      chk("rst_p", {P_RW_ACK, P_R_VALID, P_D_REQ, P_W_VALID}, 0);
      CTL_RW_ACK  = 1'b0;
      CTL_R_VALID = 1'b0;
      CTL_D_REQ   = 1'b0;
      CTL_W_VALID = 1'b0;
      RESET_N     = 1'b1;
      step();

      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < NP; i++) begin
            set_port(i, 31'h0001_2330 + 31'(i * 16),
                     4'(tbl[v].bsz + 4'(i)), tbl[v].ap[i]);
         end
         issue(tbl[v].r, tbl[v].w, tbl[v].g, tbl[v].er, tbl[v].ew,
               tbl[v].ea, tbl[v].eb, tbl[v].eap);
         run_txn(tbl[v].g, tbl[v].er, tbl[v].nb, tbl[v].dly, 1);
         step();
      end

      // All ports keep writing: grants must rotate 0,1,2,3,0.
      for (int i = 0; i < NP; i++) begin
         set_port(i, 31'h0002_0000 + 31'(i), 4'd1, 1'b0);
      end
      for (int e = 0; e < 5; e++) begin
         g = 4'(1 << (e % NP));
         issue(4'b0000, 4'b1111, g, 0, 1,
               31'h0002_0000 + 31'(e % NP), 4'd1, 0);
         run_txn(g, 0, 1, 0, 0);
      end
      P_W_REQ = '0;
      step();

      // Isolation: stray R_VALID in IDLE and inside a write burst.
      CTL_R_VALID = 1'b1;
      #1;
      chk("iso_idle", P_R_VALID, 0);
      step();
      CTL_R_VALID = 1'b0;
      chk("iso_idle_busy", {BUSY, GRANT}, 0);
      set_port(0, 31'h0000_0C00, 4'd2, 1'b0);
      issue(4'b0000, 4'b0001, 4'b0001, 0, 1, 31'h0000_0C00, 4'd2, 0);
      P_W_REQ    = '0;
      CTL_RW_ACK = 1'b1;
      step();
      CTL_RW_ACK = 1'b0;
      repeat (2) begin
         CTL_R_VALID = 1'b1;
         #1;
         chk("iso_rv_others", P_R_VALID[3:1], 0);
         chk("iso_rv_owner", P_R_VALID[0], 1);
         step();
         CTL_R_VALID = 1'b0;
         chk("iso_busy", BUSY, 1);
      end
      beats(4'b0001, 0, 2);
      step();

      // Move the pointer to 3, then reset in the middle of a read.
      set_port(2, 31'h0000_5000, 4'd1, 1'b1);
      issue(4'b0000, 4'b0100, 4'b0100, 0, 1, 31'h0000_5000, 4'd1, 1);
      run_txn(4'b0100, 0, 1, 0, 1);
      step();
      set_port(1, 31'h0ABC_DEF0, 4'd8, 1'b0);
      issue(4'b0010, 4'b0000, 4'b0010, 1, 0, 31'h0ABC_DEF0, 4'd8, 0);
      P_R_REQ    = '0;
      CTL_RW_ACK = 1'b1;
      step();
      CTL_RW_ACK = 1'b0;
      repeat (2) begin
         CTL_R_VALID = 1'b1;
         step();
         CTL_R_VALID = 1'b0;
      end
      chk("pre_rst_busy", BUSY, 1);
      CTL_R_VALID = 1'b1;
      RESET_N     = 1'b0;
      #1;
      chk("mid_rst_grant", GRANT, 0);
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_ctl", {CTL_R_REQ, CTL_W_REQ, CTL_B_SIZE, CTL_AUTO_PCH}, 0);
      chk("mid_rst_raddr", CTL_RADDR, 0);
      chk("mid_rst_p", P_R_VALID, 0);
      CTL_R_VALID = 1'b0;
      step();
      RESET_N = 1'b1;
      step();
      issue(4'b1010, 4'b0000, 4'b0010, 1, 0, 31'h0ABC_DEF0, 4'd8, 0);
      run_txn(4'b0010, 1, 8, 1, 1);
      step();
      set_port(3, 31'h7FFF_FFFF, 4'd3, 1'b1);
      issue(4'b1000, 4'b0000, 4'b1000, 1, 0, 31'h7FFF_FFFF, 4'd3, 1);
      run_txn(4'b1000, 1, 3, 0, 1);
      step();

      // Random traffic against the rotation rule.
      mptr = 0;
      for (int t = 0; t < 40; t++) begin
         rm = 4'($urandom);
         wm = 4'($urandom);
         if ($urandom_range(0, 4) == 0) begin
            rm = '0;
            wm = '0;
         end
         for (int i = 0; i < NP; i++) begin
            ra[i]  = 31'($urandom);
            rb[i]  = 4'($urandom_range(0, 6));
            rap[i] = 1'($urandom);
            set_port(i, ra[i], rb[i], rap[i]);
         end
         req = rm | wm;
         if (req == 4'b0000) begin
            P_R_REQ = '0;
            P_W_REQ = '0;
            step();
            chk("rand_idle", {BUSY, GRANT}, 0);
            continue;
         end
         w = -1;
         for (int k = 0; k < NP; k++) begin
            idx = (mptr + k) % NP;
            if (w < 0 && req[idx]) begin
               w = idx;
            end
         end
         g = 4'(1 << w);
         issue(rm, wm, g, rm[w], wm[w] & ~rm[w], ra[w], rb[w], rap[w]);
         run_txn(g, rm[w], (rb[w] == 4'd0) ? 16 : int'(rb[w]),
                 $urandom_range(0, 3), 1);
         mptr = (w + 1) % NP;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
